// File: rtl/genius_pkg.sv
// Shared definitions for the button front-end and the game logic:
// button count, symbol encoding and the event FSM states.
package genius_pkg;

  localparam int NUM_BTN = 3;
  localparam int SYM_W   = 2;

  localparam logic [SYM_W-1:0] SYM_BTN0 = 2'd0;
  localparam logic [SYM_W-1:0] SYM_BTN1 = 2'd1;
  localparam logic [SYM_W-1:0] SYM_BTN2 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } evt_state_e;

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic             multi;
  } evt_t;

  // Lowest pressed button wins; an empty vector never reaches this.
  function automatic logic [SYM_W-1:0] lowest_btn(input logic [NUM_BTN-1:0] v);
    if (v[0])      return SYM_BTN0;
    else if (v[1]) return SYM_BTN1;
    else           return SYM_BTN2;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stability counter.
// The level only flips after DEBOUNCE_CYCLES consecutive samples that
// disagree with it, so shorter glitches are invisible downstream.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Count disagreeing samples; flip the level on the last one and restart.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and debounced level registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_event_encoder.sv
// Button front-end: debounces the raw keys, turns each physical press into
// one symbol event and holds it in a single-entry valid/ack buffer.
module btn_event_encoder
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               enable,
  input  logic               evt_ack,
  output logic               evt_valid,
  output logic [SYM_W-1:0]   evt_symbol,
  output logic               evt_multi,
  output logic               overrun,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] btn_pressed;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_prev_q;
  logic [NUM_BTN-1:0] press_edge;
  evt_state_e         state_q;
  logic               evt_valid_q;
  evt_t               evt_q;
  evt_t               new_evt;
  logic               overrun_q;
  logic               fire;
  logic               load;

  // Downstream logic is always active-high "pressed".
  assign btn_pressed = BTN_ACTIVE_LOW ? ~btn : btn;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .din   (btn_pressed[i]),
      .level (level[i])
    );
  end

  // Press detection and whether this cycle produces / stores an event.
  always_comb begin
    press_edge    = level & ~level_prev_q;
    fire          = enable && (state_q == ST_IDLE) && (|press_edge);
    load          = fire && (!evt_valid_q || evt_ack);
    new_evt.sym   = lowest_btn(press_edge);
    new_evt.multi = ($countones(press_edge) > 1);
  end

  // One event per press: HOLD masks further edges until all keys are up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      level_prev_q <= '0;
      evt_valid_q  <= 1'b0;
      evt_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      level_prev_q <= level;
      overrun_q    <= 1'b0;
      if (!enable) begin
        // Keys already down when enable returns must not count as presses.
        evt_valid_q <= 1'b0;
        evt_q       <= '0;
        state_q     <= (|level) ? ST_HOLD : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (fire) state_q <= ST_HOLD;
          ST_HOLD: if (level == '0) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
        if (load) begin
          evt_valid_q <= 1'b1;
          evt_q       <= new_evt;
        end else if (evt_ack) begin
          evt_valid_q <= 1'b0;
        end
        if (fire && !load) overrun_q <= 1'b1;
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_symbol = evt_q.sym;
  assign evt_multi  = evt_q.multi;
  assign overrun    = overrun_q;
  assign btn_level  = level;

endmodule

// File: tb/tb_btn_event_encoder.sv
// Directed plus random stimulus for btn_event_encoder. A window-based
// debounce model predicts every stored event and overrun; a separate
// monitor compares them when the DUT presents them.
module tb_btn_event_encoder;

  localparam int D  = 4;
  localparam int HW = 8;

  typedef struct {
    int         stamp;
    logic [1:0] sym;
    logic       multi;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [2:0] btn;
  logic       enable;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_symbol;
  logic       evt_multi;
  logic       overrun;
  logic [2:0] btn_level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t evq[$];
  int   ovq[$];

  // reference model state
  logic [2:0] hist [0:HW-1];
  logic [2:0] m_lvl, m_prev;
  logic       m_hold, m_valid;

  btn_event_encoder #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn        (btn),
    .enable     (enable),
    .evt_ack    (evt_ack),
    .evt_valid  (evt_valid),
    .evt_symbol (evt_symbol),
    .evt_multi  (evt_multi),
    .overrun    (overrun),
    .btn_level  (btn_level)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < HW; i++) hist[i] = 3'b000;
    m_lvl = 3'b000; m_prev = 3'b000; m_hold = 1'b0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs at a negedge, predict the next edge, advance.
  task automatic step(input logic [2:0] raw, input logic en, input logic ack);
    logic [2:0] nlvl, pe;
    logic       flip;
    exp_t       e;
    btn = raw; enable = en; evt_ack = ack;
    for (int i = HW - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ~raw;
    // Level flips once the last D synchronised samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_lvl[b]) flip = 1'b0;
      nlvl[b] = flip ? ~m_lvl[b] : m_lvl[b];
    end
    pe = m_lvl & ~m_prev;
    if (!en) begin
      m_valid = 1'b0;
      m_hold  = (m_lvl != 3'b000);
    end else if (!m_hold && pe != 3'b000) begin
      m_hold = 1'b1;
      if (!m_valid || ack) begin
        m_valid = 1'b1;
        e.stamp = cyc + 1;
        e.sym   = 2'd2;
        for (int b = 2; b >= 0; b--) if (pe[b]) e.sym = 2'(b);
        e.multi = ($countones(pe) >= 2);
        evq.push_back(e);
      end else begin
        ovq.push_back(cyc + 1);
      end
    end else begin
      if (ack) m_valid = 1'b0;
      if (m_hold && m_lvl == 3'b000) m_hold = 1'b0;
    end
    m_prev = m_lvl;
    m_lvl  = nlvl;
    @(negedge clock);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, released at the next negedge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_symbol", evt_symbol, 0);
    chk("rst_multi", evt_multi, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_level", btn_level, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: compare each newly presented event and each overrun pulse.
  initial begin
    logic pv;
    exp_t e;
    int   s;
    pv = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        pv = 1'b0;
      end else begin
        if (evt_valid && (!pv || evt_ack)) begin
          if (evq.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = evq.pop_front();
            chk("evt_time", cyc, e.stamp);
            chk("evt_symbol", evt_symbol, e.sym);
            chk("evt_multi", evt_multi, e.multi);
          end
        end
        if (overrun) begin
          if (ovq.size() == 0) chk("unexpected_overrun", 1, 0);
          else begin
            s = ovq.pop_front();
            chk("overrun_time", cyc, s);
          end
        end
        pv = evt_valid;
      end
    end
  end

  initial begin
    reset = 1'b0; btn = 3'b111; enable = 1'b1; evt_ack = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    chk("reset_valid", evt_valid, 0);
    chk("reset_symbol", evt_symbol, 0);
    chk("reset_multi", evt_multi, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_level", btn_level, 0);
    reset = 1'b1;
    repeat (2) step(3'b111, 1, 0);

    // btn[1] press: latency, hold until ack, fall after ack
    repeat (6) step(3'b101, 1, 0);
    chk("t1_pre_latency", evt_valid, 0);
    step(3'b101, 1, 0);
    chk("t1_valid", evt_valid, 1);
    chk("t1_symbol", evt_symbol, 1);
    chk("t1_multi", evt_multi, 0);
    repeat (3) step(3'b101, 1, 0);
    chk("t1_hold", evt_valid, 1);
    step(3'b101, 1, 1);
    chk("t1_after_ack", evt_valid, 0);
    repeat (10) step(3'b111, 1, 0);

    // bouncing btn[0], then settled press
    repeat (3) begin
      repeat (2) step(3'b110, 1, 0);
      repeat (2) step(3'b111, 1, 0);
    end
    repeat (12) step(3'b110, 1, 1);
    repeat (10) step(3'b111, 1, 0);

    // 3-cycle glitch on btn[2] must not reach the level
    repeat (3) begin
      step(3'b011, 1, 0);
      chk("t2_glitch_level", btn_level[2], 0);
    end
    repeat (10) begin
      step(3'b111, 1, 0);
      chk("t2_glitch_level", btn_level[2], 0);
    end

    // btn[0] and btn[2] together
    repeat (12) step(3'b010, 1, 0);
    chk("t3_valid", evt_valid, 1);
    chk("t3_symbol", evt_symbol, 0);
    chk("t3_multi", evt_multi, 1);
    step(3'b010, 1, 1);
    repeat (10) step(3'b111, 1, 0);

    // overrun: btn[1] pending, then btn[2] press
    repeat (10) step(3'b101, 1, 0);
    repeat (10) step(3'b111, 1, 0);
    repeat (6) step(3'b011, 1, 0);
    chk("t4_no_early_overrun", overrun, 0);
    step(3'b011, 1, 0);
    chk("t4_overrun", overrun, 1);
    chk("t4_kept_valid", evt_valid, 1);
    chk("t4_kept_symbol", evt_symbol, 1);
    step(3'b011, 1, 0);
    chk("t4_overrun_pulse", overrun, 0);
    repeat (5) step(3'b011, 1, 0);
    repeat (10) step(3'b111, 1, 0);
    // same again with ack in the load cycle
    repeat (6) step(3'b011, 1, 0);
    step(3'b011, 1, 1);
    chk("t4b_valid", evt_valid, 1);
    chk("t4b_symbol", evt_symbol, 2);
    chk("t4b_overrun", overrun, 0);
    repeat (3) step(3'b011, 1, 0);
    step(3'b011, 1, 1);
    repeat (10) step(3'b111, 1, 0);

    // key held across enable rising gives no event
    repeat (10) step(3'b110, 0, 0);
    chk("t5_disabled", evt_valid, 0);
    repeat (5) step(3'b110, 1, 0);
    repeat (10) step(3'b111, 1, 0);
    chk("t5_no_event", evt_valid, 0);
    repeat (10) step(3'b101, 1, 0);
    chk("t5_next_valid", evt_valid, 1);
    chk("t5_next_symbol", evt_symbol, 1);
    step(3'b101, 1, 1);
    repeat (10) step(3'b111, 1, 0);

    // reset in the middle of a held btn[2] press
    repeat (5) step(3'b011, 1, 0);
    do_reset();
    repeat (10) step(3'b011, 1, 0);
    chk("t6_valid", evt_valid, 1);
    chk("t6_symbol", evt_symbol, 2);
    step(3'b011, 1, 1);
    repeat (10) step(3'b111, 1, 0);

    // random segments: glitches, overlaps, random ack and enable
    repeat (250) begin
      logic [2:0] pat;
      logic       en;
      int         dur;
      pat = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 12);
      en  = ($urandom_range(0, 15) != 0);
      repeat (dur) step(pat, en, ($urandom_range(0, 3) == 0));
    end
    repeat (20) step(3'b111, 1, 1);

    chk("events_outstanding", evq.size(), 0);
    chk("overruns_outstanding", ovq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
